pipe_forward_ctrl: RTL
======================

PIPE_FORWARD_CTRL -- requirements
Module: pipe_forward_ctrl

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
- clk  in  1  sole clock, rising edge.
- clrn  in  1  reset, asynchronous, active-high (1 = clear).
- IDrs, IDrt  in  5 each  source register numbers of the instruction in ID.
- IDuseRs, IDuseRt  in  1 each  the ID instruction reads rs / rt.
- IDaluaImm  in  1  alua takes saOrImme (shift amount).
- IDalubImm  in  1  alub takes saOrImme (immediate).
- IDwreg, IDm2reg, IDwmem  in  1 each  ID instruction writes a register / is a load / is a store.
- IDwn  in  5  destination register of the ID instruction.
- EXflush  in  1  taken jump or branch resolved in EX this cycle.
- selectAlua, selectAlub  out  2 each  operand select into ID/EX: 0 = qa/qb, 1 = saOrImme, 2 = MEMaluResult, 3 = WBdata.
- isStoreHazards  out  1  the store's data must be replaced by WBdata in MEM.
- stall  out  1  hold PC and the IF/ID register.
- bubble  out  1  load all-zero control (wreg = m2reg = wmem = 0) into ID/EX.
- stallCount  out  16  number of load-use stall cycles, saturating.

Function
REQ-002 The block SHALL keep shadow registers exW/exM/exN (wreg, m2reg, wn of the instruction in EX) and memW/memM/memN (the same fields for MEM), all updated on the rising edge of clk.
REQ-003 Each cycle the MEM shadow SHALL load the EX shadow.
- If bubble = 1, the EX shadow SHALL load wreg = 0, m2reg = 0, wn = 0.
- Otherwise the EX shadow SHALL load IDwreg, IDm2reg, IDwn.
REQ-004 A match is defined as: producer wreg = 1, producer wn equal to the source register, and source register not equal to 0. Register 0 SHALL never match.
REQ-005 selectAlua SHALL be combinational, evaluated in this priority:
- IDaluaImm -> 1
- else IDuseRs and rs matches the EX shadow with exM = 0 -> 2
- else IDuseRs and rs matches the MEM shadow -> 3
- else -> 0
REQ-006 selectAlub SHALL follow the same priority as REQ-005, using IDalubImm, IDuseRt and rt.
REQ-007 An EX-shadow match SHALL take precedence over a MEM-shadow match, so the youngest producer wins.
REQ-008 A load-use hazard SHALL be flagged when exM = 1 and the EX shadow matches either:
- rs, with IDuseRs = 1 and IDaluaImm = 0, or
- rt, with IDuseRt = 1 and IDalubImm = 0.
REQ-009 A store-data hazard SHALL be flagged when IDwmem = 1, IDuseRt = 1, rt matches the MEM shadow, and rt does not match the EX shadow.
REQ-010 stall and bubble SHALL both equal (load-use hazard OR store-data hazard) AND NOT EXflush.
- While stalled, selectAlua and selectAlub keep their combinational values; they are don't-care because bubble = 1.
REQ-011 isStoreHazards SHALL be 1 when IDwmem = 1, IDuseRt = 1, rt matches the EX shadow (load or ALU producer), and stall = 0. Otherwise it SHALL be 0.
- No stall is needed in this case: WBdata holds the value when the store reaches MEM.
REQ-012 When EXflush = 1:
- bubble SHALL be 1, squashing the ID instruction.
- stall SHALL be 0.
- isStoreHazards SHALL be 0.
- The EX shadow SHALL load the bubble values.
REQ-013 stallCount SHALL increment by 1 on each rising edge where stall = 1, and SHALL hold at 16'hFFFF without wrapping.
REQ-014 A stall SHALL last exactly one cycle per load-use hazard. On the next cycle the load sits in the MEM shadow, the hazard clears, and the select becomes 3.

Reset
REQ-015 While clrn = 1, the block SHALL asynchronously clear all shadow registers to 0 and stallCount to 0.
REQ-016 During and after reset, with the shadows cleared, stall, bubble and isStoreHazards SHALL be 0, and the selects SHALL depend only on IDaluaImm and IDalubImm.
REQ-017 Reset asserted mid-stall SHALL drop stall in the same cycle, and no count SHALL be added.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- ALU forward: add r3 (ID), then sub rs=r3, rt=r4 -> next cycle selectAlua = 2, selectAlub = 0; one cycle later an unrelated instruction with rs=r3 -> selectAlua = 3.
- Load-use: lw r5, then add rs=r5 -> stall = bubble = 1 for exactly one cycle, then selectAlua = 3 and stallCount = 1.
- Store data: lw r6, then sw rt=r6 -> isStoreHazards = 1, stall = 0. ALU r7, nop, sw rt=r7 -> one stall cycle, then isStoreHazards = 0 and selectAlub = 1.
- r0 and immediate: producer wn = 0, consumer rs = 0 -> selectAlua = 0. Consumer with IDalubImm = 1 and rt matching -> selectAlub = 1.
- Flush vs stall: load-use condition with EXflush = 1 -> stall = 0, bubble = 1, stallCount unchanged, and the following instruction sees no forward from the squashed one.
- Saturation and reset: preload 65534 stalls, then 3 more -> stallCount = 16'hFFFF. Assert clrn mid-stall -> all outputs 0 immediately.

Source files
------------

// File: rtl/pipe_forward_ctrl_if.sv
`default_nettype none
// =============================================================================
// Module      : pipe_forward_ctrl_if
// Description : ID-stage hazard/forwarding bundle between pipeline and control.
// Revision    : 1.0 - initial release
// =============================================================================
interface pipe_forward_ctrl_if;
  logic [4:0]  IDrs;
  logic [4:0]  IDrt;
  logic        IDuseRs;
  logic        IDuseRt;
  logic        IDaluaImm;
  logic        IDalubImm;
  logic        IDwreg;
  logic        IDm2reg;
  logic        IDwmem;
  logic [4:0]  IDwn;
  logic        EXflush;
  logic [1:0]  selectAlua;
  logic [1:0]  selectAlub;
  logic        isStoreHazards;
  logic        stall;
  logic        bubble;
  logic [15:0] stallCount;

  modport master (
    output IDrs, IDrt, IDuseRs, IDuseRt, IDaluaImm, IDalubImm,
           IDwreg, IDm2reg, IDwmem, IDwn, EXflush,
    input  selectAlua, selectAlub, isStoreHazards, stall, bubble, stallCount
  );

  modport slave (
    input  IDrs, IDrt, IDuseRs, IDuseRt, IDaluaImm, IDalubImm,
           IDwreg, IDm2reg, IDwmem, IDwn, EXflush,
    output selectAlua, selectAlub, isStoreHazards, stall, bubble, stallCount
  );
endinterface
`default_nettype wire

// File: rtl/pipe_forward_ctrl.sv
`default_nettype none
// =============================================================================
// Module      : pipe_forward_ctrl
// Description : Operand forwarding, load-use/store stall and bubble control.
// Revision    : 1.0 - initial release
// =============================================================================
module pipe_forward_ctrl (
  input  logic                clk,
  input  logic                clrn,
  pipe_forward_ctrl_if.slave  bus
);
  localparam logic [1:0]  c_SEL_REG = 2'd0;
  localparam logic [1:0]  c_SEL_IMM = 2'd1;
  localparam logic [1:0]  c_SEL_MEM = 2'd2;
  localparam logic [1:0]  c_SEL_WB  = 2'd3;
  localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

  logic        ex_w_q,  ex_w_d;
  logic        ex_m_q,  ex_m_d;
  logic [4:0]  ex_n_q,  ex_n_d;
  logic        mem_w_q, mem_w_d;
  logic        mem_m_q, mem_m_d;
  logic [4:0]  mem_n_q, mem_n_d;
  logic [15:0] stall_count_q, stall_count_d;

  logic w_rs_ex, w_rs_mem, w_rt_ex, w_rt_mem;
  logic w_mem_prod;
  logic w_load_use, w_store_haz, w_hazard;
  logic w_stall, w_bubble;

  // A load in MEM forwards through WBdata exactly like an ALU result.
  assign w_mem_prod = mem_w_q | (mem_m_q & mem_w_q);

  assign w_rs_ex  = ex_w_q     && (ex_n_q  == bus.IDrs) && (bus.IDrs != 5'd0);
  assign w_rs_mem = w_mem_prod && (mem_n_q == bus.IDrs) && (bus.IDrs != 5'd0);
  assign w_rt_ex  = ex_w_q     && (ex_n_q  == bus.IDrt) && (bus.IDrt != 5'd0);
  assign w_rt_mem = w_mem_prod && (mem_n_q == bus.IDrt) && (bus.IDrt != 5'd0);

  always_comb begin
    bus.selectAlua = c_SEL_REG;
    if (bus.IDaluaImm)                     bus.selectAlua = c_SEL_IMM;
    else if (bus.IDuseRs && w_rs_ex && !ex_m_q) bus.selectAlua = c_SEL_MEM;
    else if (bus.IDuseRs && w_rs_mem)      bus.selectAlua = c_SEL_WB;
  end

  always_comb begin
    bus.selectAlub = c_SEL_REG;
    if (bus.IDalubImm)                     bus.selectAlub = c_SEL_IMM;
    else if (bus.IDuseRt && w_rt_ex && !ex_m_q) bus.selectAlub = c_SEL_MEM;
    else if (bus.IDuseRt && w_rt_mem)      bus.selectAlub = c_SEL_WB;
  end

  assign w_load_use  = ex_m_q && ((w_rs_ex && bus.IDuseRs && !bus.IDaluaImm) ||
                                  (w_rt_ex && bus.IDuseRt && !bus.IDalubImm));
  assign w_store_haz = bus.IDwmem && bus.IDuseRt && w_rt_mem && !w_rt_ex;
  assign w_hazard    = w_load_use || w_store_haz;

  // A flush squashes the ID instruction, so it bubbles but never needs to stall.
  assign w_stall  = w_hazard && !bus.EXflush && !clrn;
  assign w_bubble = (w_hazard || bus.EXflush) && !clrn;

  assign bus.stall          = w_stall;
  assign bus.bubble         = w_bubble;
  assign bus.isStoreHazards = bus.IDwmem && bus.IDuseRt && w_rt_ex &&
                              !w_stall && !bus.EXflush && !clrn;
  assign bus.stallCount     = stall_count_q;

  always_comb begin
    ex_w_d        = bus.IDwreg;
    ex_m_d        = bus.IDm2reg;
    ex_n_d        = bus.IDwn;
    if (w_bubble) begin
      ex_w_d = 1'b0;
      ex_m_d = 1'b0;
      ex_n_d = 5'd0;
    end
    mem_w_d       = ex_w_q;
    mem_m_d       = ex_m_q;
    mem_n_d       = ex_n_q;
    stall_count_d = stall_count_q;
    if (w_stall && (stall_count_q != c_CNT_MAX)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      ex_w_q        <= 1'b0;
      ex_m_q        <= 1'b0;
      ex_n_q        <= 5'd0;
      mem_w_q       <= 1'b0;
      mem_m_q       <= 1'b0;
      mem_n_q       <= 5'd0;
      stall_count_q <= 16'd0;
    end else begin
      ex_w_q        <= ex_w_d;
      ex_m_q        <= ex_m_d;
      ex_n_q        <= ex_n_d;
      mem_w_q       <= mem_w_d;
      mem_m_q       <= mem_m_d;
      mem_n_q       <= mem_n_d;
      stall_count_q <= stall_count_d;
    end
  end
endmodule
`default_nettype wire
